// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling: two-flop input synchroniser, then a start/data/stop FSM
// that samples each bit at its centre and emits a one-cycle done or framing-error pulse.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic [DBIT-1:0] dout,
  output logic [1:0]      fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [4:0] START_MID = 5'd7;
  localparam logic [4:0] BIT_END   = 5'd15;
  localparam logic [4:0] STOP_END  = 5'(SB_TICK - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DBIT - 1);

  state_t          state;
  logic [4:0]      s_cnt;
  logic [2:0]      n_cnt;
  logic [DBIT-1:0] shreg;
  logic            rx_meta;
  logic            rx_s;

  assign fsm_state = state;

  // Idle-high line, so the synchroniser resets to 1 to avoid a false start after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Output handshake: rx_done_tick is a valid-only strobe with no ready/backpressure; dout is
  // valid from that cycle and holds until the next frame completes (good or errored).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      shreg        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_cnt == START_MID) begin
              // Still low at mid-start: a real start bit; otherwise treat it as a glitch.
              if (!rx_s) begin
                state <= DATA;
                s_cnt <= '0;
                n_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_cnt == BIT_END) begin
              s_cnt <= '0;
              shreg <= {rx_s, shreg[DBIT-1:1]};
              if (n_cnt == LAST_BIT) begin
                state <= STOP;
              end else begin
                n_cnt <= n_cnt + 3'd1;
              end
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_cnt == STOP_END) begin
              // Leave mid stop bit so the next start edge is caught with no dead time.
              state        <= IDLE;
              dout         <= shreg;
              rx_done_tick <= rx_s;
              frame_err    <= ~rx_s;
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
